// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM state and
// owner encodings, the default abort timeout and the cycle-counter width.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_L = 1'b1
  } owner_t;

  // Default number of BUSY cycles before an access is aborted (1..255)
  localparam int TMO_DEFAULT = 15;

  // Eight bits hold any legal timeout value
  localparam int CNT_W = 8;

endpackage

// File: rtl/imem_arbiter_pick.sv
// Combinational two-way grant between fetch and loader.
// With IMEM_ARB_RR_EN defined, a tie goes to the port that was not served
// last; otherwise fetch always wins a tie and no history input exists.
module arb_pick
  import imem_arbiter_pkg::*;
(
  input  logic   f_req,
  input  logic   l_req,
`ifdef IMEM_ARB_RR_EN
  input  owner_t last,
`endif
  output logic   grant,
  output owner_t owner
);

  // Pick the owner for the next access from the current requests
  always_comb begin
    grant = f_req | l_req;
    owner = OWN_F;
    if (f_req && l_req) begin
`ifdef IMEM_ARB_RR_EN
      owner = (last == OWN_F) ? OWN_L : OWN_F;
`else
      owner = OWN_F;
`endif
    end else if (l_req) begin
      owner = OWN_L;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter and sequencer.
// Serialises fetch (read-only) and loader (read/write) accesses onto one
// req/ack memory port, returns data with a one-cycle valid pulse and aborts
// accesses that see no ack within TMO cycles.
// Optional feature: define IMEM_ARB_RR_EN for round-robin tie breaking;
// the default build uses fixed fetch priority.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int AW  = 10,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic [31:0]   f_rdata,
  output logic          f_rvalid,
  output logic          f_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  output logic [31:0]   l_rdata,
  output logic          l_rvalid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

  arb_state_t       state_q;
  arb_state_t       state_d;
  owner_t           owner_q;
  owner_t           pick_owner;
  logic             pick_grant;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  logic [31:0]      resp_data;

`ifdef IMEM_ARB_RR_EN
  owner_t           last_q;
`endif

  // The counter starts at 1 in the first BUSY cycle, so reaching TMO means
  // mem_req has been high for exactly TMO cycles
  assign timeout   = (cnt_q == TMO_C);

  // Writes and aborted accesses return zero to the requester
  assign resp_data = (mem_ack && !mem_we) ? mem_rdata : 32'd0;

  // Fetch holds its PC until its own response pulse arrives
  assign f_stall   = f_req & ~f_rvalid;

  arb_pick u_pick (
    .f_req (f_req),
    .l_req (l_req),
`ifdef IMEM_ARB_RR_EN
    .last  (last_q),
`endif
    .grant (pick_grant),
    .owner (pick_owner)
  );

  // Next-state logic; an ack in the timeout cycle still completes normally
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (pick_grant) state_d = ARB_BUSY;
      ARB_BUSY: if (mem_ack || timeout) state_d = ARB_RESP;
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight without a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Registered memory-side signals, timeout counter and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= OWN_F;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_rdata   <= '0;
      f_rvalid  <= 1'b0;
      l_rdata   <= '0;
      l_rvalid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      f_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      err      <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_grant) begin
            owner_q   <= pick_owner;
            cnt_q     <= CNT_W'(1);
            mem_req   <= 1'b1;
            mem_addr  <= (pick_owner == OWN_L) ? l_addr : f_addr;
            mem_we    <= (pick_owner == OWN_L) ? l_we : 1'b0;
            mem_wdata <= (pick_owner == OWN_L) ? l_wdata : 32'd0;
          end
        end
        ARB_BUSY: begin
          if (mem_ack || timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= ~mem_ack;
            if (owner_q == OWN_F) begin
              f_rvalid <= 1'b1;
              f_rdata  <= resp_data;
            end else begin
              l_rvalid <= 1'b1;
              l_rdata  <= resp_data;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Remember who was served so the next tie goes to the other port
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       last_q <= OWN_L;
    else if (state_q == ARB_RESP)  last_q <= owner_q;
  end
`endif

endmodule
